// File: rtl/color_event_filter.sv
// Debounces the colour-sensor code into a stable colour, counts promotions per
// colour, and queues "new colour" events in a small FWFT FIFO for the controller.
module color_event_filter #(
   parameter int CONFIRM_CYCLES = 1000,
   parameter int NONE_HOLD      = 512,
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       color,
   input  logic             ev_ready,
   output logic [1:0]       stable_color,
   output logic             ev_valid,
   output logic [1:0]       ev_color,
   output logic [CNT_W-1:0] count_r,
   output logic [CNT_W-1:0] count_g,
   output logic [CNT_W-1:0] count_b,
   output logic             overflow
);

   localparam int MW = $clog2(CONFIRM_CYCLES + 1);
   localparam int ZW = $clog2(NONE_HOLD + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = $clog2(FIFO_DEPTH + 1);

   localparam logic [MW-1:0]    MATCH_MAX = MW'(CONFIRM_CYCLES);
   localparam logic [ZW-1:0]    ZERO_MAX  = ZW'(NONE_HOLD);
   localparam logic [ZW-1:0]    ZERO_LAST = ZW'(NONE_HOLD - 1);
   localparam logic [OW-1:0]    OCC_FULL  = OW'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [1:0]       cand_q, cand_d;
   logic [MW-1:0]    matchCnt_q, matchCnt_d;
   logic [ZW-1:0]    zeroRun_q, zeroRun_d;
   logic [1:0]       stable_q, stable_d;
   logic [CNT_W-1:0] countR_q, countR_d;
   logic [CNT_W-1:0] countG_q, countG_d;
   logic [CNT_W-1:0] countB_q, countB_d;
   logic             overflow_q, overflow_d;

   logic [1:0]       mem_q [FIFO_DEPTH];
   logic [1:0]       mem_d [FIFO_DEPTH];
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW-1:0]    wr_q, wr_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic [1:0]       evColor_q, evColor_d;

   logic [1:0]       cleanColor;
   logic             promote;
   logic             pop;
   logic             full;
   logic             doWrite;

   // Codes 4..7 carry no colour and are folded into "none".
   assign cleanColor = color[2] ? 2'd0 : color[1:0];

   assign promote = (matchCnt_q == MATCH_MAX) && (cand_q != 2'd0) && (cand_q != stable_q);

   always_comb begin
      cand_d     = cand_q;
      matchCnt_d = matchCnt_q;
      zeroRun_d  = zeroRun_q;
      stable_d   = stable_q;
      countR_d   = countR_q;
      countG_d   = countG_q;
      countB_d   = countB_q;

      if (promote) begin
         stable_d = cand_q;
         case (cand_q)
            2'd1:    if (countR_q != CNT_MAX) countR_d = countR_q + CNT_W'(1);
            2'd2:    if (countG_q != CNT_MAX) countG_d = countG_q + CNT_W'(1);
            default: if (countB_q != CNT_MAX) countB_d = countB_q + CNT_W'(1);
         endcase
      end

      if (cleanColor != 2'd0) begin
         zeroRun_d = '0;
         if (cleanColor == cand_q) begin
            if (matchCnt_q != MATCH_MAX) matchCnt_d = matchCnt_q + MW'(1);
         end else begin
            cand_d     = cleanColor;
            matchCnt_d = MW'(1);
         end
      end else begin
         if (zeroRun_q != ZERO_MAX) zeroRun_d = zeroRun_q + ZW'(1);
         // A long enough gap forgets the candidate so the same colour can re-promote.
         if (zeroRun_q == ZERO_LAST) begin
            cand_d     = 2'd0;
            matchCnt_d = '0;
            stable_d   = 2'd0;
         end
      end
   end

   assign pop     = (occ_q != '0) && ev_ready;
   assign full    = (occ_q == OCC_FULL);
   assign doWrite = promote && (!full || pop);

   always_comb begin
      mem_d      = mem_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      overflow_d = overflow_q;

      if (doWrite) begin
         mem_d[wr_q] = cand_q;
         wr_d        = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      if (promote && full && !pop) overflow_d = 1'b1;

      occ_d = occ_q + OW'(doWrite) - OW'(pop);
      // Head is read from the post-write image so a push into an emptying FIFO shows at once.
      evColor_d = (occ_d == '0) ? 2'd0 : mem_d[rd_d];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_q     <= 2'd0;
         matchCnt_q <= '0;
         zeroRun_q  <= '0;
         stable_q   <= 2'd0;
         countR_q   <= '0;
         countG_q   <= '0;
         countB_q   <= '0;
         overflow_q <= 1'b0;
         mem_q      <= '{default: 2'd0};
         rd_q       <= '0;
         wr_q       <= '0;
         occ_q      <= '0;
         evColor_q  <= 2'd0;
      end else begin
         cand_q     <= cand_d;
         matchCnt_q <= matchCnt_d;
         zeroRun_q  <= zeroRun_d;
         stable_q   <= stable_d;
         countR_q   <= countR_d;
         countG_q   <= countG_d;
         countB_q   <= countB_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         occ_q      <= occ_d;
         evColor_q  <= evColor_d;
      end
   end

   assign stable_color = stable_q;
   assign ev_valid     = (occ_q != '0);
   assign ev_color     = evColor_q;
   assign count_r      = countR_q;
   assign count_g      = countG_q;
   assign count_b      = countB_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_color_event_filter.sv
// Bench for color_event_filter: table-driven steps through a scoreboard queue,
// plus hand sequences for the full-FIFO push/pop edge and counter saturation.
module tb_color_event_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, ev_ready;
   logic [2:0] color;
   logic [1:0] stable_color, ev_color;
   logic       ev_valid, overflow;
   logic [7:0] count_r, count_g, count_b;

   logic       rst2N, ready2;
   logic [2:0] color2;
   logic [1:0] stable2, evColor2;
   logic       evValid2, overflow2;
   logic [1:0] countR2, countG2, countB2;

   color_event_filter #(.CONFIRM_CYCLES(4), .NONE_HOLD(3), .FIFO_DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .color(color), .ev_ready(ev_ready),
      .stable_color(stable_color), .ev_valid(ev_valid), .ev_color(ev_color),
      .count_r(count_r), .count_g(count_g), .count_b(count_b), .overflow(overflow)
   );

   color_event_filter #(.CONFIRM_CYCLES(4), .NONE_HOLD(3), .FIFO_DEPTH(4), .CNT_W(2)) dutSat (
      .clk(clk), .rst_n(rst2N), .color(color2), .ev_ready(ready2),
      .stable_color(stable2), .ev_valid(evValid2), .ev_color(evColor2),
      .count_r(countR2), .count_g(countG2), .count_b(countB2), .overflow(overflow2)
   );

   typedef struct {
      logic       rstN;
      logic [2:0] color;
      logic       ready;
      int         cycles;
      logic [1:0] expStable;
      logic       expValid;
      logic [1:0] expEvColor;
      logic [7:0] expR;
      logic [7:0] expG;
      logic [7:0] expB;
      logic       expOvf;
   } step_t;

   step_t      steps[$];
   step_t      expQ[$];
   logic [1:0] evQ[$];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic step_t mk(input logic rstN, input logic [2:0] c, input logic rdy, input int n,
                                input logic [1:0] st, input logic v, input logic [1:0] ec,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic ov);
      step_t s;
      s.rstN = rstN; s.color = c; s.ready = rdy; s.cycles = n;
      s.expStable = st; s.expValid = v; s.expEvColor = ec;
      s.expR = r; s.expG = g; s.expB = b; s.expOvf = ov;
      return s;
   endfunction

   // Drive one step's inputs for its cycle count, queueing what the outputs must then be.
   task automatic applyStimulus(input step_t s);
      rst_n    = s.rstN;
      color    = s.color;
      ev_ready = s.ready;
      expQ.push_back(s);
      repeat (s.cycles) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input int idx);
      step_t e;
      if (expQ.size() == 0) begin
         check($sformatf("step%0d.scoreboard", idx), 32'd0, 32'd1);
         return;
      end
      e = expQ.pop_front();
      check($sformatf("step%0d.stable", idx),   stable_color, e.expStable);
      check($sformatf("step%0d.ev_valid", idx), ev_valid,     e.expValid);
      check($sformatf("step%0d.ev_color", idx), ev_color,     e.expEvColor);
      check($sformatf("step%0d.count_r", idx),  count_r,      e.expR);
      check($sformatf("step%0d.count_g", idx),  count_g,      e.expG);
      check($sformatf("step%0d.count_b", idx),  count_b,      e.expB);
      check($sformatf("step%0d.overflow", idx), overflow,     e.expOvf);
   endtask

   task automatic holdColor(input logic [2:0] c, input int n);
      color = c;
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Pops one event and compares it against the next expected event.
   task automatic drainOne(input string name);
      logic [1:0] want;
      ev_ready = 1'b1;
      if (evQ.size() == 0) begin
         check({name, ".evq"}, 32'd0, 32'd1);
      end else begin
         want = evQ.pop_front();
         check({name, ".valid"}, ev_valid, 32'd1);
         check({name, ".color"}, ev_color, want);
      end
      @(posedge clk);
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; color = 3'd0; ev_ready = 1'b0;
      rst2N = 1'b0; color2 = 3'd0; ready2 = 1'b1;

      //                rst   color  rdy  n  stable v     evc    R     G     B     ovf
      steps.push_back(mk(1'b0, 3'd0, 1'b0, 2, 2'd0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 4, 2'd0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 1, 2'd1, 1'b1, 2'd1, 8'd1, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b1, 1, 2'd1, 1'b0, 2'd0, 8'd1, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 3, 2'd1, 1'b0, 2'd0, 8'd1, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b0, 2, 2'd1, 1'b0, 2'd0, 8'd1, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd0, 1'b0, 2, 2'd1, 1'b0, 2'd0, 8'd1, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b0, 2, 2'd1, 1'b0, 2'd0, 8'd1, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b0, 1, 2'd2, 1'b1, 2'd2, 8'd1, 8'd1, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b1, 1, 2'd2, 1'b0, 2'd0, 8'd1, 8'd1, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b0, 2, 2'd2, 1'b0, 2'd0, 8'd1, 8'd1, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd3, 1'b0, 4, 2'd2, 1'b0, 2'd0, 8'd1, 8'd1, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd3, 1'b0, 1, 2'd3, 1'b1, 2'd3, 8'd1, 8'd1, 8'd1, 1'b0));
      steps.push_back(mk(1'b1, 3'd0, 1'b1, 2, 2'd3, 1'b0, 2'd0, 8'd1, 8'd1, 8'd1, 1'b0));
      steps.push_back(mk(1'b1, 3'd0, 1'b0, 1, 2'd0, 1'b0, 2'd0, 8'd1, 8'd1, 8'd1, 1'b0));
      steps.push_back(mk(1'b1, 3'd0, 1'b0, 2, 2'd0, 1'b0, 2'd0, 8'd1, 8'd1, 8'd1, 1'b0));
      steps.push_back(mk(1'b1, 3'd3, 1'b0, 4, 2'd0, 1'b0, 2'd0, 8'd1, 8'd1, 8'd1, 1'b0));
      steps.push_back(mk(1'b1, 3'd3, 1'b0, 1, 2'd3, 1'b1, 2'd3, 8'd1, 8'd1, 8'd2, 1'b0));
      steps.push_back(mk(1'b1, 3'd3, 1'b1, 1, 2'd3, 1'b0, 2'd0, 8'd1, 8'd1, 8'd2, 1'b0));
      steps.push_back(mk(1'b1, 3'd5, 1'b0, 2, 2'd3, 1'b0, 2'd0, 8'd1, 8'd1, 8'd2, 1'b0));
      steps.push_back(mk(1'b1, 3'd5, 1'b0, 1, 2'd0, 1'b0, 2'd0, 8'd1, 8'd1, 8'd2, 1'b0));
      steps.push_back(mk(1'b0, 3'd0, 1'b0, 1, 2'd0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 4, 2'd0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b0, 4, 2'd1, 1'b1, 2'd1, 8'd1, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd3, 1'b0, 4, 2'd2, 1'b1, 2'd1, 8'd1, 8'd1, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 4, 2'd3, 1'b1, 2'd1, 8'd1, 8'd1, 8'd1, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b0, 4, 2'd1, 1'b1, 2'd1, 8'd2, 8'd1, 8'd1, 1'b0));
      steps.push_back(mk(1'b1, 3'd2, 1'b0, 1, 2'd2, 1'b1, 2'd1, 8'd2, 8'd2, 8'd1, 1'b1));
      steps.push_back(mk(1'b1, 3'd2, 1'b1, 1, 2'd2, 1'b1, 2'd2, 8'd2, 8'd2, 8'd1, 1'b1));
      steps.push_back(mk(1'b1, 3'd2, 1'b1, 1, 2'd2, 1'b1, 2'd3, 8'd2, 8'd2, 8'd1, 1'b1));
      steps.push_back(mk(1'b1, 3'd2, 1'b1, 1, 2'd2, 1'b1, 2'd1, 8'd2, 8'd2, 8'd1, 1'b1));
      steps.push_back(mk(1'b1, 3'd2, 1'b1, 1, 2'd2, 1'b0, 2'd0, 8'd2, 8'd2, 8'd1, 1'b1));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 2, 2'd2, 1'b0, 2'd0, 8'd2, 8'd2, 8'd1, 1'b1));
      steps.push_back(mk(1'b0, 3'd1, 1'b0, 1, 2'd0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 4, 2'd0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0));
      steps.push_back(mk(1'b1, 3'd1, 1'b0, 1, 2'd1, 1'b1, 2'd1, 8'd1, 8'd0, 8'd0, 1'b0));

      @(negedge clk);
      foreach (steps[i]) begin
         applyStimulus(steps[i]);
         checkOutput(i);
      end

      // Full FIFO: pop and push land on the same edge, nothing is dropped.
      rst_n = 1'b0; color = 3'd0; ev_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      holdColor(3'd1, 4); evQ.push_back(2'd1);
      holdColor(3'd2, 4); evQ.push_back(2'd2);
      holdColor(3'd3, 4); evQ.push_back(2'd3);
      holdColor(3'd1, 4); evQ.push_back(2'd1);
      holdColor(3'd2, 4);
      check("full.valid", ev_valid, 32'd1);
      check("full.overflow", overflow, 32'd0);
      evQ.push_back(2'd2);
      drainOne("simul");
      check("simul.overflow", overflow, 32'd0);
      check("simul.count_g", count_g, 32'd2);
      for (int k = 0; k < 4; k++) drainOne($sformatf("drain%0d", k));
      check("drained.valid", ev_valid, 32'd0);
      check("drained.overflow", overflow, 32'd0);

      // Narrow counters must stick at their maximum.
      rst2N = 1'b1;
      for (int i = 0; i < 5; i++) begin
         color2 = 3'd1;
         repeat (5) @(posedge clk);
         @(negedge clk);
         check($sformatf("sat%0d.stable", i), stable2, 32'd1);
         check($sformatf("sat%0d.count_r", i), countR2, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
         color2 = 3'd0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check($sformatf("sat%0d.none", i), stable2, 32'd0);
      end
      check("sat.overflow", overflow2, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
